// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the pc_seq program-counter sequencer.
package pc_pkg;
    typedef enum logic [1:0] {VEC_LO, VEC_HI, RUN} state_t;
    localparam logic [2:0] ACT_RET  = 3'd0;
    localparam logic [2:0] ACT_CALL = 3'd1;
    localparam logic [2:0] ACT_BRA  = 3'd2;
    localparam logic [2:0] ACT_REL  = 3'd3;
    localparam logic [2:0] ACT_INC  = 3'd4;
    localparam logic [2:0] ACT_HOLD = 3'd5;
    localparam logic [31:0] DEF_VEC_ADDR = 32'h0000_FFFC;
endpackage

// File: rtl/pc_ret_stack.sv
// pc_ret_stack: LIFO of return addresses; push when full and pop when empty are ignored.
module pc_ret_stack #(
    parameter int AW = 16,
    parameter int STACK_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] din,
    output logic [AW-1:0] dout,
    output logic          full,
    output logic          empty
);
    localparam int PW = $clog2(STACK_DEPTH);
    localparam logic [PW:0] FULL_CNT = STACK_DEPTH[PW:0];
    logic [AW-1:0] mem [STACK_DEPTH];
    logic [PW:0] cnt;
    logic [PW-1:0] ptr;
    assign ptr   = cnt[PW-1:0];
    assign full  = cnt == FULL_CNT;
    assign empty = cnt == '0;
    // when full, ptr wraps to 0 so ptr-1 still addresses the last entry
    assign dout  = mem[ptr - 1'b1];
    always_ff @(posedge clk) begin
        if (push && !full) mem[ptr] <= din;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt <= '0;
        else if (push && !full) cnt <= cnt + 1'b1;
        else if (pop && !empty) cnt <= cnt - 1'b1;
    end
endmodule

// File: rtl/pc_seq.sv
// pc_seq: fetches the start address from a reset vector, then sequences the PC
// by return, call, branch, relative branch or increment, one action per cycle.
module pc_seq
    import pc_pkg::*;
#(
    parameter int AW = 16,
    parameter logic [AW-1:0] VEC_ADDR = AW'(DEF_VEC_ADDR),
    parameter int STACK_DEPTH = 4,
    parameter int OFFW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            branch,
    input  logic [AW-1:0]   bra_add,
    input  logic            rel_branch,
    input  logic [OFFW-1:0] rel_off,
    input  logic            increment,
    input  logic [1:0]      inc_amt,
    input  logic            call,
    input  logic            ret,
    output logic            vec_req,
    output logic [AW-1:0]   vec_addr,
    input  logic [7:0]      vec_data,
    input  logic            vec_ack,
    output logic [AW-1:0]   address,
    output logic            ready,
    output logic            stk_overflow,
    output logic            stk_underflow
);
    state_t state, state_nx;
    logic [AW-1:0] addr_nx, ret_addr, top;
    logic [7:0] lo, lo_nx;
    logic ovf_nx, unf_nx, full, empty;
    logic [2:0] act;

    assign act = state != RUN ? ACT_HOLD :
                 ret          ? ACT_RET  :
                 call         ? ACT_CALL :
                 branch       ? ACT_BRA  :
                 rel_branch   ? ACT_REL  :
                 increment    ? ACT_INC  : ACT_HOLD;
    assign ret_addr = address + AW'(inc_amt);
    assign vec_req  = state != RUN;
    assign ready    = state == RUN;
    assign vec_addr = state == VEC_LO ? VEC_ADDR : VEC_ADDR + 1'b1;

    pc_ret_stack #(.AW(AW), .STACK_DEPTH(STACK_DEPTH)) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (act == ACT_CALL),
        .pop   (act == ACT_RET),
        .din   (ret_addr),
        .dout  (top),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_nx = state;
        addr_nx  = address;
        lo_nx    = lo;
        ovf_nx   = stk_overflow;
        unf_nx   = stk_underflow;
        if (state == VEC_LO && vec_ack) begin
            lo_nx    = vec_data;
            state_nx = VEC_HI;
        end
        if (state == VEC_HI && vec_ack) begin
            addr_nx  = AW'({vec_data, lo});
            state_nx = RUN;
        end
        case (act)
            ACT_RET: begin
                addr_nx = empty ? address : top;
                unf_nx  = stk_underflow | empty;
            end
            ACT_CALL: begin
                addr_nx = bra_add;
                ovf_nx  = stk_overflow | full;
            end
            ACT_BRA: addr_nx = bra_add;
            ACT_REL: addr_nx = address + AW'($signed(rel_off));
            ACT_INC: addr_nx = ret_addr;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= VEC_LO;
            address       <= VEC_ADDR;
            lo            <= '0;
            stk_overflow  <= 1'b0;
            stk_underflow <= 1'b0;
        end else begin
            state         <= state_nx;
            address       <= addr_nx;
            lo            <= lo_nx;
            stk_overflow  <= ovf_nx;
            stk_underflow <= unf_nx;
        end
    end
endmodule

// File: doc/pc_seq.md
Name: pc_seq

Overview:
Parametrised program-counter sequencer for the MOSby core; next generation of the current PC block.
- After reset, fetches the start address from a reset vector over a byte-wide request/acknowledge handshake; no fixed hard-wired start address.
- In run mode: absolute branch, signed relative branch, variable-length increment, and call/return through an internal return-address stack with sticky overflow/underflow flags.
- Sits between the instruction decoder (control inputs) and the memory address mux (address output).

Parameters:
AW, 16, address width; legal range 9..32.
VEC_ADDR, 16'hFFFC, address of the low byte of the reset vector; high byte is at VEC_ADDR+1 (mod 2^AW).
STACK_DEPTH, 4, return-stack entries; power of two, 2..16.
OFFW, 8, width of the signed relative-branch offset.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  asynchronous, active-low reset.
branch  in  1  absolute jump to bra_add.
bra_add  in  AW  absolute target; also the call target.
rel_branch  in  1  relative jump by rel_off.
rel_off  in  OFFW  signed two's-complement offset.
increment  in  1  advance address by inc_amt.
inc_amt  in  2  increment step 0..3; also the return-address skip for call.
call  in  1  push return address, jump to bra_add.
ret  in  1  pop the return stack into address.
vec_req  out  1  vector byte read request.
vec_addr  out  AW  vector byte address.
vec_data  in  8  vector byte returned by memory.
vec_ack  in  1  vec_data valid this cycle.
address  out  AW  current program counter.
ready  out  1  high in RUN; the decoder may issue controls.
stk_overflow  out  1  sticky: a call occurred with the stack full.
stk_underflow  out  1  sticky: a ret occurred with the stack empty.

Behaviour:
- Reset (rst low, asynchronous):
  - state=VEC_LO, address=VEC_ADDR, vec_req=1, vec_addr=VEC_ADDR, ready=0.
  - Stack emptied; both sticky flags=0; internal low-byte latch=0.
- Reset released mid-operation: all progress is lost; the sequencer restarts at VEC_LO.
- FSM states: VEC_LO -> VEC_HI -> RUN. RUN is terminal until the next reset.
- VEC_LO: waits for vec_ack. On vec_ack: latch vec_data as lo, set vec_addr=VEC_ADDR+1, go to VEC_HI. vec_req stays 1.
- VEC_HI: on vec_ack:
  - address = {vec_data, lo}, zero-extended to AW, or truncated if AW<16.
  - vec_req=0, ready=1, go to RUN.
- Reset fetch latency: minimum 2 cycles from reset release to ready=1, one per acknowledged byte. vec_ack wait states are unbounded.
- vec_ack while in RUN is ignored. All control inputs are ignored while not in RUN.
- RUN: one action per cycle, in this priority order: ret > call > branch > rel_branch > increment > hold.
  - ret, stack non-empty: address = top entry; pop.
  - ret, stack empty: address holds; stk_underflow=1.
  - call: push (address + inc_amt) mod 2^AW, then address=bra_add.
  - call with stack full: jump still taken; push discarded; stk_overflow=1.
  - branch: address=bra_add.
  - rel_branch: address = address + sign_extend(rel_off), mod 2^AW.
  - increment: address = address + inc_amt, mod 2^AW. inc_amt=0 behaves as hold.
- Wrap-around: all address arithmetic is modulo 2^AW (e.g. FFFF+1 -> 0000; 0002 + (-4) -> FFFE).
- Simultaneous asserts: the lower-priority request is dropped entirely, with no partial effect (e.g. call+ret: ret wins, no push).
- Sticky flags are cleared only by reset.
- All outputs are registered; address updates one cycle after the control input is sampled.

Decomposition:
- Package pc_pkg holds:
  - state enum (VEC_LO, VEC_HI, RUN);
  - action encoding constants (ACT_RET, ACT_CALL, ACT_BRA, ACT_REL, ACT_INC, ACT_HOLD);
  - default VEC_ADDR.
- Sub-module pc_ret_stack is a LIFO with:
  - parameters AW, STACK_DEPTH;
  - ports push, pop, din, dout, full, empty;
  - same clk/rst as pc_seq.
- pc_seq contains the FSM, priority decode and adders.

Test Plan:
- Reset vector fetch: release rst; ack vec_data=CA at FFFC, then 12 at FFFD, with 2 wait cycles each -> ready=1 and address=12CA one cycle after the second ack; vec_req=0 afterwards.
- Increment and wrap: address=FFFE, increment with inc_amt=3 -> 0001. inc_amt=0 -> address holds.
- Relative branch: address=1000, rel_off=80 (-128) -> 0F80. Then rel_off=7F -> 0FFF.
- Call/return: at 2000, call with inc_amt=3, bra_add=3000 -> address 3000. Then ret -> 2003. Nested calls up to depth 4 return in LIFO order.
- Stack boundaries: 5 calls with depth 4 -> stk_overflow=1, fifth jump still taken. 5 rets -> fourth pops the oldest valid entry, fifth holds address and sets stk_underflow=1. Flags persist until rst.
- Priority and reset mid-op:
  - ret+call+branch in one cycle -> only the ret takes effect.
  - rst low during VEC_HI -> address=FFFC, vec_addr=FFFC, ready=0 immediately, without waiting for a clock edge.
